// File: rtl/dram_request_queue_pkg.sv
// Shared types for the trace-parser to DRAM-controller request path:
// opcode enum, decoded address fields and the queue entry layout.
package dram_request_queue_pkg;

  localparam int ADDRESS_WIDTH   = 32;
  localparam int BG_BITS         = 2;
  localparam int BANK_BITS       = 2;
  localparam int COLUMN_BITS     = 8;
  localparam int ROW_BITS        = 14;
  localparam int LIFE_WIDTH      = 7;
  localparam int CPU_CLOCK_WIDTH = 64;

  typedef enum logic [1:0] {
    DATA_READ    = 2'd0,
    DATA_WRITE   = 2'd1,
    OPCODE_FETCH = 2'd2,
    NOP          = 2'd3
  } parsed_op_t;

  typedef struct packed {
    logic [BG_BITS-1:0]     bg;
    logic [BANK_BITS-1:0]   bank;
    logic [COLUMN_BITS-1:0] column;
    logic [ROW_BITS-1:0]    row;
  } decoded_addr_t;

  typedef struct packed {
    logic [CPU_CLOCK_WIDTH-1:0] cpu_clock;
    parsed_op_t                 opcode;
    logic [ADDRESS_WIDTH-1:0]   address;
    decoded_addr_t              decoded;
    logic [LIFE_WIDTH-1:0]      age;
  } req_entry_t;

  // Age counters stick at all-ones so a long-stalled head never looks young again.
  function automatic logic [LIFE_WIDTH-1:0] age_step(input logic [LIFE_WIDTH-1:0] age);
    return (&age) ? age : age + LIFE_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dram_request_queue_if.sv
// Enqueue/dequeue bundle of the request queue. The slave side is the queue,
// the master side drives requests in and takes the head out.
interface dram_request_queue_if #(
  parameter int DEPTH = 16
);
  import dram_request_queue_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  parsed_op_t                  in_opcode;
  logic [ADDRESS_WIDTH-1:0]    in_address;
  logic [CPU_CLOCK_WIDTH-1:0]  in_cpu_clock;

  logic                        out_valid;
  logic                        out_ready;
  parsed_op_t                  out_opcode;
  logic [ADDRESS_WIDTH-1:0]    out_address;
  logic [BG_BITS-1:0]          out_bank_group;
  logic [BANK_BITS-1:0]        out_bank;
  logic [COLUMN_BITS-1:0]      out_column;
  logic [ROW_BITS-1:0]         out_row;
  logic [CPU_CLOCK_WIDTH-1:0]  out_cpu_clock;
  logic [LIFE_WIDTH-1:0]       out_age;
  logic                        head_expired;
  logic [$clog2(DEPTH):0]      count;

  modport slave (
    input  in_valid, in_opcode, in_address, in_cpu_clock, out_ready,
    output in_ready, out_valid, out_opcode, out_address, out_bank_group,
           out_bank, out_column, out_row, out_cpu_clock, out_age,
           head_expired, count
  );

  modport master (
    output in_valid, in_opcode, in_address, in_cpu_clock, out_ready,
    input  in_ready, out_valid, out_opcode, out_address, out_bank_group,
           out_bank, out_column, out_row, out_cpu_clock, out_age,
           head_expired, count
  );

endinterface

// File: rtl/dram_addr_decode.sv
// Combinational split of a physical address into bank group, bank, column
// and row; offsets and widths are parameters so the controller can reuse it.
module dram_addr_decode #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BG_OFFSET     = 6,
  parameter int BG_BITS       = 2,
  parameter int BANK_OFFSET   = 8,
  parameter int BANK_BITS     = 2,
  parameter int COLUMN_OFFSET = 10,
  parameter int COLUMN_BITS   = 8,
  parameter int ROW_OFFSET    = 18,
  parameter int ROW_BITS      = 14
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic [BG_BITS-1:0]       bank_group,
  output logic [BANK_BITS-1:0]     bank,
  output logic [COLUMN_BITS-1:0]   column,
  output logic [ROW_BITS-1:0]      row
);

  // Shift then truncate: equivalent to (address >> OFFSET) & mask.
  assign bank_group = BG_BITS'(address >> BG_OFFSET);
  assign bank       = BANK_BITS'(address >> BANK_OFFSET);
  assign column     = COLUMN_BITS'(address >> COLUMN_OFFSET);
  assign row        = ROW_BITS'(address >> ROW_OFFSET);

endmodule

// File: rtl/dram_request_queue.sv
// In-order request queue between trace parser and DRAM controller: drops NOPs,
// decodes addresses at enqueue and ages resident entries for starvation flagging.
module dram_request_queue
  import dram_request_queue_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int BG_OFFSET     = 6,
  parameter int BANK_OFFSET   = 8,
  parameter int COLUMN_OFFSET = 10,
  parameter int ROW_OFFSET    = 18,
  parameter int LIFE_LIMIT    = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  dram_request_queue_if.slave  q
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;

  req_entry_t             entries [DEPTH];
  logic [DEPTH-1:0]       valid;
  logic [PTR_WIDTH-1:0]   head;
  logic [PTR_WIDTH-1:0]   tail;
  logic [COUNT_WIDTH-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  logic [BG_BITS-1:0]     dec_bg;
  logic [BANK_BITS-1:0]   dec_bank;
  logic [COLUMN_BITS-1:0] dec_column;
  logic [ROW_BITS-1:0]    dec_row;
  req_entry_t             head_entry;

  dram_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .BG_OFFSET     (BG_OFFSET),
    .BG_BITS       (BG_BITS),
    .BANK_OFFSET   (BANK_OFFSET),
    .BANK_BITS     (BANK_BITS),
    .COLUMN_OFFSET (COLUMN_OFFSET),
    .COLUMN_BITS   (COLUMN_BITS),
    .ROW_OFFSET    (ROW_OFFSET),
    .ROW_BITS      (ROW_BITS)
  ) u_decode (
    .address    (q.in_address),
    .bank_group (dec_bg),
    .bank       (dec_bank),
    .column     (dec_column),
    .row        (dec_row)
  );

  // in_ready depends only on occupancy, so a pop never frees room for a same-cycle push.
  assign full       = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = q.in_valid && !full && (q.in_opcode != NOP);
  assign pop        = !empty && q.out_ready;
  assign head_entry = entries[head];

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.count     = count_q;

  always_comb begin
    q.out_opcode     = DATA_READ;
    q.out_address    = '0;
    q.out_bank_group = '0;
    q.out_bank       = '0;
    q.out_column     = '0;
    q.out_row        = '0;
    q.out_cpu_clock  = '0;
    q.out_age        = '0;
    q.head_expired   = 1'b0;
    if (!empty) begin
      q.out_opcode     = head_entry.opcode;
      q.out_address    = head_entry.address;
      q.out_bank_group = head_entry.decoded.bg;
      q.out_bank       = head_entry.decoded.bank;
      q.out_column     = head_entry.decoded.column;
      q.out_row        = head_entry.decoded.row;
      q.out_cpu_clock  = head_entry.cpu_clock;
      q.out_age        = head_entry.age;
      q.head_expired   = (head_entry.age >= LIFE_WIDTH'(LIFE_LIMIT));
    end
  end

  // The push write comes last so a freshly written slot starts at age 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          entries[i].age <= age_step(entries[i].age);
        end
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_WIDTH'(1);
      end
      if (push) begin
        valid[tail]   <= 1'b1;
        entries[tail] <= '{cpu_clock: q.in_cpu_clock,
                           opcode:    q.in_opcode,
                           address:   q.in_address,
                           decoded:   '{bg: dec_bg, bank: dec_bank,
                                        column: dec_column, row: dec_row},
                           age:       '0};
        tail          <= tail + PTR_WIDTH'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_request_queue.sv
// Directed bench for dram_request_queue: decode, NOP drop, full/empty, aging,
// streaming push+pop and mid-operation reset, checked against hand values.
module tb_dram_request_queue;
  import dram_request_queue_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_addr [16];
  logic [63:0] exp_cpu  [16];
  parsed_op_t  exp_op   [16];
  logic [31:0] model [$];
  logic [31:0] addr;
  int          seq;

  dram_request_queue_if #(.DEPTH(16)) dut_if ();

  dram_request_queue #(.DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .q     (dut_if)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs are driven 1 time unit after a posedge; outputs are read at the same point.
  task automatic applyStimulus(input logic valid_i, input parsed_op_t op, input logic [31:0] a,
                               input logic [63:0] cpu, input logic ready);
    dut_if.in_valid     = valid_i;
    dut_if.in_opcode    = op;
    dut_if.in_address   = a;
    dut_if.in_cpu_clock = cpu;
    dut_if.out_ready    = ready;
    @(posedge clock);
    #1;
  endtask

  task automatic applyIdle(input int n);
    repeat (n) applyStimulus(1'b0, DATA_READ, 32'h0, 64'h0, 1'b0);
  endtask

  initial begin
    // Reset with a request presented: must be ignored.
    reset = 1'b1;
    applyStimulus(1'b1, DATA_READ, 32'h1234_5678, 64'd1, 1'b0);
    applyStimulus(1'b1, DATA_READ, 32'h1234_5678, 64'd1, 1'b0);
    reset = 1'b0;
    checkOutput("rst_count", dut_if.count, 0);
    checkOutput("rst_out_valid", dut_if.out_valid, 0);
    checkOutput("rst_in_ready", dut_if.in_ready, 1);
    checkOutput("rst_expired", dut_if.head_expired, 0);
    checkOutput("rst_out_address", dut_if.out_address, 0);
    checkOutput("rst_out_row", dut_if.out_row, 0);

    // Single READ: decode of 0x0004_A5C0 visible the cycle after push.
    applyStimulus(1'b1, DATA_READ, 32'h0004_A5C0, 64'd123, 1'b0);
    checkOutput("dec_out_valid", dut_if.out_valid, 1);
    checkOutput("dec_bg", dut_if.out_bank_group, 3);
    checkOutput("dec_bank", dut_if.out_bank, 1);
    checkOutput("dec_column", dut_if.out_column, 8'h29);
    checkOutput("dec_row", dut_if.out_row, 1);
    checkOutput("dec_age", dut_if.out_age, 0);
    checkOutput("dec_cpu", dut_if.out_cpu_clock, 123);
    checkOutput("dec_opcode", dut_if.out_opcode, DATA_READ);
    checkOutput("dec_count", dut_if.count, 1);
    applyStimulus(1'b0, DATA_READ, 32'h0, 64'h0, 1'b1);
    checkOutput("dec_pop_count", dut_if.count, 0);
    checkOutput("dec_pop_valid", dut_if.out_valid, 0);

    // NOP is consumed without being stored; out_ready on empty is harmless.
    applyStimulus(1'b1, NOP, 32'hFFFF_FFC0, 64'd9, 1'b1);
    checkOutput("nop_count", dut_if.count, 0);
    checkOutput("nop_out_valid", dut_if.out_valid, 0);

    // Fill to DEPTH, then a 17th push (first alone, then alongside a pop).
    for (int i = 0; i < 16; i++) begin
      exp_addr[i] = 32'h0000_0040 + 32'(i) * 32'h0000_1100;
      exp_cpu[i]  = 64'd1000 + 64'(i);
      exp_op[i]   = parsed_op_t'(2'(i % 3));
      applyStimulus(1'b1, exp_op[i], exp_addr[i], exp_cpu[i], 1'b0);
    end
    checkOutput("full_count", dut_if.count, 16);
    checkOutput("full_in_ready", dut_if.in_ready, 0);
    applyStimulus(1'b1, DATA_WRITE, 32'hBAD0_0000, 64'd77, 1'b0);
    checkOutput("full_push_ignored", dut_if.count, 16);
    checkOutput("full_head", dut_if.out_address, exp_addr[0]);
    checkOutput("full_pop0_addr", dut_if.out_address, exp_addr[0]);
    applyStimulus(1'b1, DATA_WRITE, 32'hBAD0_0000, 64'd77, 1'b1);
    checkOutput("full_pushpop_count", dut_if.count, 15);
    for (int i = 1; i < 16; i++) begin
      checkOutput("drain_addr", dut_if.out_address, exp_addr[i]);
      checkOutput("drain_cpu", dut_if.out_cpu_clock, exp_cpu[i]);
      checkOutput("drain_op", dut_if.out_opcode, exp_op[i]);
      applyStimulus(1'b0, DATA_READ, 32'h0, 64'h0, 1'b1);
    end
    checkOutput("drain_count", dut_if.count, 0);
    checkOutput("drain_out_valid", dut_if.out_valid, 0);
    checkOutput("drain_in_ready", dut_if.in_ready, 1);

    // Aging: threshold boundary at 99/100, saturation at 127.
    applyStimulus(1'b1, OPCODE_FETCH, 32'hDEAD_BEC0, 64'd7, 1'b0);
    checkOutput("age_start", dut_if.out_age, 0);
    applyIdle(99);
    checkOutput("age_99", dut_if.out_age, 99);
    checkOutput("expired_99", dut_if.head_expired, 0);
    applyIdle(1);
    checkOutput("age_100", dut_if.out_age, 100);
    checkOutput("expired_100", dut_if.head_expired, 1);
    checkOutput("expired_still_valid", dut_if.out_valid, 1);
    applyIdle(27);
    checkOutput("age_127", dut_if.out_age, 127);
    applyIdle(173);
    checkOutput("age_saturated", dut_if.out_age, 127);
    checkOutput("expired_saturated", dut_if.head_expired, 1);
    checkOutput("age_head_addr", dut_if.out_address, 32'hDEAD_BEC0);
    applyStimulus(1'b0, DATA_READ, 32'h0, 64'h0, 1'b1);
    checkOutput("age_pop_expired", dut_if.head_expired, 0);
    checkOutput("age_pop_count", dut_if.count, 0);

    // Half full, then push+pop every cycle for 40 cycles (wraps pointers).
    seq = 1;
    for (int i = 0; i < 8; i++) begin
      addr = 32'(seq) * 32'h0001_0400;
      model.push_back(addr);
      applyStimulus(1'b1, DATA_WRITE, addr, 64'(seq), 1'b0);
      seq++;
    end
    checkOutput("half_count", dut_if.count, 8);
    for (int c = 0; c < 40; c++) begin
      checkOutput("stream_head", dut_if.out_address, model[0]);
      addr = 32'(seq) * 32'h0001_0400;
      model.push_back(addr);
      void'(model.pop_front());
      applyStimulus(1'b1, DATA_WRITE, addr, 64'(seq), 1'b1);
      seq++;
      checkOutput("stream_count", dut_if.count, 8);
    end
    while (model.size() > 0) begin
      checkOutput("stream_drain", dut_if.out_address, model[0]);
      void'(model.pop_front());
      applyStimulus(1'b0, DATA_READ, 32'h0, 64'h0, 1'b1);
    end
    checkOutput("stream_empty", dut_if.out_valid, 0);

    // Mid-operation reset discards contents; next push starts fresh.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DATA_READ, 32'h0000_1000 + 32'(i), 64'(i), 1'b0);
    end
    checkOutput("pre_reset_count", dut_if.count, 5);
    reset = 1'b1;
    applyStimulus(1'b1, DATA_READ, 32'h5555_0000, 64'd5, 1'b0);
    reset = 1'b0;
    checkOutput("mid_rst_count", dut_if.count, 0);
    checkOutput("mid_rst_out_valid", dut_if.out_valid, 0);
    checkOutput("mid_rst_in_ready", dut_if.in_ready, 1);
    applyStimulus(1'b1, DATA_WRITE, 32'h00FF_FFC0, 64'd42, 1'b0);
    checkOutput("post_rst_count", dut_if.count, 1);
    checkOutput("post_rst_addr", dut_if.out_address, 32'h00FF_FFC0);
    checkOutput("post_rst_age", dut_if.out_age, 0);
    checkOutput("post_rst_bg", dut_if.out_bank_group, 3);
    checkOutput("post_rst_row", dut_if.out_row, 14'h3F);
    applyIdle(1);
    checkOutput("post_rst_age1", dut_if.out_age, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
